div16_8_seq: RTL
================

DIV16_8_SEQ -- requirements
Module: div16_8_seq

Interface
REQ-001 Parameter N, default 8, divisor/quotient/remainder width; dividend width is 2N.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand pair presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 dividend  input  2N  unsigned dividend (a full mult8 product P).
REQ-008 divisor  input  N  unsigned divisor.
REQ-009 out_valid  output  1  result presented.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 quotient  output  N  unsigned quotient.
REQ-012 remainder  output  N  unsigned remainder.
REQ-013 status  output  2  00 ok, 01 divide-by-zero, 10 overflow (quotient exceeds N bits).

Function
REQ-014 FSM states IDLE, CALC, DONE; in_ready SHALL be 1 only in IDLE, and out_valid 1 only in DONE.
REQ-015 Accept SHALL occur on an edge with in_valid && in_ready; operands are registered on that edge and dividend/divisor inputs are ignored afterwards.
REQ-016 On accept, divisor==0 SHALL go IDLE->DONE directly: status=01, quotient all-ones, remainder=dividend[N-1:0].
REQ-017 On accept, divisor!=0 and dividend[2N-1:N] >= divisor SHALL go IDLE->DONE directly: status=10, quotient all-ones, remainder=dividend[N-1:0].
REQ-018 Otherwise IDLE->CALC, with partial remainder initialised to dividend[2N-1:N] and status=00.
REQ-019 CALC SHALL perform restoring division, one quotient bit per cycle, MSB first: trial = {rem, next dividend bit} (N+1 bits) minus divisor; if non-negative, rem=trial[N-1:0] and qbit=1, else rem keeps the shifted value and qbit=0.
REQ-020 CALC SHALL last exactly N cycles, counted by a ceil(log2(N+1))-bit iteration counter; after the Nth iteration edge the FSM enters DONE.
REQ-021 Latency: for valid operands out_valid SHALL rise N edges after the accept edge (8 for N=8); for error cases, 1 edge after.
REQ-022 Results SHALL satisfy quotient*divisor + remainder == dividend and remainder < divisor whenever status=00.
REQ-023 In DONE, quotient/remainder/status SHALL hold stable until out_valid && out_ready; that edge returns the FSM to IDLE.
REQ-024 No new operand SHALL be accepted on the same edge as result handoff (in_ready rises one cycle after handoff).
REQ-025 out_ready is ignored outside DONE; in_valid is ignored outside IDLE.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, status=00, counter=0.
REQ-027 Reset asserted mid-CALC or in DONE SHALL abandon the operation with no result output; after release the first edge may accept new operands.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, the status code constants (OK, DIV0, OVF), and the default N.
REQ-029 The per-iteration trial subtract/select SHALL be a combinational sub-module div_step (inputs rem, bit, divisor; outputs new rem, qbit); the top contains the FSM, counter and registers only.

Verification
REQ-030 dividend=3700, divisor=37 -> status=00, quotient=100, remainder=0, out_valid 8 cycles after accept.
REQ-031 dividend=3707, divisor=37 -> quotient=100, remainder=7; then 16'h00FF/8'h01 -> quotient=255, remainder=0.
REQ-032 divisor=0, dividend=16'h1234 -> status=01, quotient=8'hFF, remainder=8'h34, out_valid 1 cycle after accept.
REQ-033 dividend=16'h2500, divisor=8'h25 -> status=10, quotient=8'hFF, remainder=8'h00; dividend=16'h24FF, divisor=8'h25 -> status=00, quotient=8'hFF, remainder=8'h24.
REQ-034 out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0 throughout; handoff edge -> IDLE, in_ready=1 next cycle.
REQ-035 rst_n pulsed low at iteration 4 of 3700/37 -> outputs reset immediately, no out_valid; next operation 200/3 -> quotient=66, remainder=2.

Source files
------------

// File: rtl/div16_8_seq_pkg.sv
// -----------------------------------------------------------------------------
// div16_8_seq_pkg
//   Shared definitions for the sequential 2N/N restoring divider:
//   - DIV_N        : default divisor / quotient / remainder width
//   - state_e      : controller states (IDLE, CALC, DONE)
//   - ST_OK/DIV0/OVF : result status codes driven on the status port
// -----------------------------------------------------------------------------
package div16_8_seq_pkg;

    localparam int DIV_N = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_e;

    localparam logic [1:0] ST_OK   = 2'b00;  // quotient/remainder are exact
    localparam logic [1:0] ST_DIV0 = 2'b01;  // divisor was zero
    localparam logic [1:0] ST_OVF  = 2'b10;  // quotient would not fit in N bits

endpackage : div16_8_seq_pkg

// File: rtl/div16_8_seq_div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One restoring-division iteration, purely combinational.
//   The partial remainder is shifted left with the next dividend bit appended
//   (N+1 bits) and the divisor is trial-subtracted. A non-negative trial keeps
//   the difference and yields quotient bit 1; otherwise the shifted value is
//   kept and the quotient bit is 0.
//
//   Ports
//     rem_i     [N-1:0]  partial remainder entering the step (always < divisor)
//     bit_i              next dividend bit, MSB first
//     divisor_i [N-1:0]  divisor (non-zero while iterating)
//     rem_o     [N-1:0]  partial remainder leaving the step
//     qbit_o             quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
    import div16_8_seq_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic [N-1:0] rem_i,
    input  logic         bit_i,
    input  logic [N-1:0] divisor_i,
    output logic [N-1:0] rem_o,
    output logic         qbit_o
);

    logic [N:0] trial;
    logic       ge;

    assign trial  = {rem_i, bit_i};
    assign ge     = (trial >= {1'b0, divisor_i});
    assign qbit_o = ge;
    // rem_i < divisor keeps both candidates below 2^N, so dropping the top
    // bit loses nothing.
    assign rem_o  = N'(ge ? (trial - {1'b0, divisor_i}) : trial);

endmodule : div_step

// File: rtl/div16_8_seq.sv
// -----------------------------------------------------------------------------
// div16_8_seq
//   Sequential unsigned divider: 2N-bit dividend by N-bit divisor, one
//   quotient bit per clock (restoring algorithm, MSB first). Valid/ready
//   handshake on both the operand and the result side.
//
//   Ports
//     clk        in        rising-edge clock
//     rst_n      in        asynchronous active-low reset
//     in_valid   in        operand pair presented
//     in_ready   out       block can accept operands (IDLE only)
//     dividend   in  2N    unsigned dividend
//     divisor    in  N     unsigned divisor
//     out_valid  out       result presented (DONE only)
//     out_ready  in        consumer accepts result
//     quotient   out N     unsigned quotient
//     remainder  out N     unsigned remainder
//     status     out 2     00 ok, 01 divide-by-zero, 10 overflow
//
//   Timing
//     Error cases (divide-by-zero, overflow) are resolved on the accept edge
//     and show up in the following cycle. Valid operands spend exactly N
//     cycles in CALC, so out_valid rises N edges after the accept edge.
//     Results hold in DONE until the handoff edge, which returns to IDLE;
//     in_ready is therefore never high on the handoff edge itself.
// -----------------------------------------------------------------------------
module div16_8_seq
    import div16_8_seq_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic [1:0]     status
);

    localparam int CW = $clog2(N + 1);

    state_e         state_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   rem_q;      // partial remainder, final remainder in DONE
    logic [N-1:0]   quo_q;      // quotient bits shifted in LSB-first position
    logic [N-1:0]   dvd_q;      // low dividend half, consumed MSB first
    logic [N-1:0]   dvs_q;      // registered divisor
    logic [1:0]     status_q;

    logic [N-1:0]   rem_d;
    logic           qbit_d;
    logic           last_iter;

    div_step #(.N(N)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[N-1]),
        .divisor_i (dvs_q),
        .rem_o     (rem_d),
        .qbit_o    (qbit_d)
    );

    assign last_iter = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            status_q    <= ST_OK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        dvs_q <= divisor;
                        dvd_q <= dividend[N-1:0];
                        cnt_q <= '0;
                        if (divisor == '0) begin
                            status_q    <= ST_DIV0;
                            quo_q       <= '1;
                            rem_q       <= dividend[N-1:0];
                            state_q     <= S_DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else if (dividend[2*N-1:N] >= divisor) begin
                            // High half >= divisor means the quotient needs
                            // more than N bits.
                            status_q    <= ST_OVF;
                            quo_q       <= '1;
                            rem_q       <= dividend[N-1:0];
                            state_q     <= S_DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            status_q    <= ST_OK;
                            quo_q       <= '0;
                            rem_q       <= dividend[2*N-1:N];
                            state_q     <= S_CALC;
                            in_ready_q  <= 1'b0;
                        end
                    end
                end

                S_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= {quo_q[N-2:0], qbit_d};
                    dvd_q <= dvd_q << 1;
                    if (last_iter) begin
                        cnt_q       <= '0;
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign status    = status_q;

endmodule : div16_8_seq
